pipeline_hazard_controller: RTL
===============================

# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It keeps a 32-entry register scoreboard of in-flight destination registers and detects RAW hazards for the instruction in decode. It freezes the whole pipeline on a data-memory wait and squashes wrong-path instructions on a taken branch. It drives the PC, IF/ID and ID/EX register controls, and exposes a stall-cycle performance counter and a memory-timeout error flag.

## Interface
- MEM_TIMEOUT, 64: MEM_WAIT cycles after which MEM_ERR sets.
- CNT_W, 16: width of STALL_COUNT.
- CLK  in  1  pipeline clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- DE_VALID  in  1  decode stage holds a valid instruction.
- DE_TYPE  in  3  instruction format code from define.v (R, I, S, B, U, J).
- DE_SRC1, DE_SRC2  in  5  decode source register indices.
- DE_RD  in  5  decode destination register index.
- WB_VALID  in  1  writeback retires a register write this cycle.
- WB_RD  in  5  register being written back.
- BRANCH_TAKEN  in  1  EX resolved a taken branch or jump this cycle.
- MEM_REQ  in  1  MEM stage is issuing a data-memory access.
- MEM_READY  in  1  data memory completes the access this cycle.
- PC_EN  out  1  PC register load enable.
- FD_EN  out  1  IF/ID register load enable.
- FD_FLUSH  out  1  clear IF/ID to NOP.
- DE_BUBBLE  out  1  load NOP into ID/EX instead of the decode instruction.
- PIPE_EN  out  1  enable for ID/EX, EX/MEM and MEM/WB registers.
- STALL_PROCESSOR  out  1  any stall or freeze active this cycle.
- BUSY_MAP  out  32  scoreboard; bit n set means xn has a pending write. Bit 0 is always 0.
- STALL_COUNT  out  CNT_W  saturating count of cycles with STALL_PROCESSOR=1.
- MEM_ERR  out  1  sticky memory-timeout flag.

## Operation
- Source use by type:
  - R, S, B read SRC1 and SRC2.
  - I reads SRC1.
  - U, J read none.
- Writers: R, I, U, J write rd. S, B do not.
- Hazard is combinational: DE_VALID & ((uses1 & BUSY_MAP[DE_SRC1]) | (uses2 & BUSY_MAP[DE_SRC2])).
  - Index 0 never hazards.
  - The registered map is used; a same-cycle WB clear does not unblock. There is no bypass, so the stall lasts one cycle longer.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when MEM_REQ & !MEM_READY.
  - MEM_WAIT -> RUN when MEM_READY.
  - Reset state: RUN.
- Output priority: MEM_WAIT entry or stay > branch flush > hazard > normal.
  - Mem freeze (RUN with MEM_REQ&!MEM_READY, or MEM_WAIT with !MEM_READY): PC_EN=FD_EN=PIPE_EN=0, DE_BUBBLE=0, FD_FLUSH=0, STALL=1.
  - Flush (RUN, BRANCH_TAKEN, no freeze): PC_EN=1, FD_EN=1, FD_FLUSH=1, DE_BUBBLE=1, PIPE_EN=1, STALL=0. The hazard is ignored because the decode instruction is squashed.
  - Hazard: PC_EN=FD_EN=0, DE_BUBBLE=1, PIPE_EN=1, STALL=1.
  - Normal: PC_EN=FD_EN=PIPE_EN=1, others 0.
  - MEM_WAIT with MEM_READY behaves as RUN for that cycle, including flush and hazard evaluation.
- Issue: DE_VALID & writer & DE_RD!=0 & PIPE_EN & !DE_BUBBLE.
- Scoreboard update per cycle:
  - Clear BUSY_MAP[WB_RD] if WB_VALID & PIPE_EN.
  - Then set BUSY_MAP[DE_RD] on issue. Set wins on the same index.
- STALL_COUNT increments when STALL_PROCESSOR=1 and saturates at all-ones.
- MEM_ERR:
  - A wait counter resets on entry to MEM_WAIT and counts each MEM_WAIT cycle.
  - MEM_ERR sets when the count reaches MEM_TIMEOUT. It clears only on reset.
  - The FSM keeps waiting after MEM_ERR sets.

## Timing
- While RESET_N=0: state RUN, BUSY_MAP=0, STALL_COUNT=0, MEM_ERR=0, wait counter=0. Also PC_EN=FD_EN=PIPE_EN=0, FD_FLUSH=1, DE_BUBBLE=1, STALL_PROCESSOR=0.
- Release: the first rising edge with RESET_N=1 runs normal behaviour.
- All control outputs are combinational from current state, BUSY_MAP and inputs, with zero-cycle latency. BUSY_MAP, STALL_COUNT and MEM_ERR change one edge after their cause.
- Load-use: the producer issues at edge k and retires at WB. The dependent stalls until the cycle after WB_VALID for that rd.
- Reset asserted mid-MEM_WAIT returns to RUN immediately. The pending scoreboard bits are lost by design.
- A single-cycle access (MEM_REQ & MEM_READY together) produces no freeze.

## Test plan
- Reset: hold RESET_N=0 for 3 cycles, then release -> BUSY_MAP=0, STALL_COUNT=0, MEM_ERR=0, PC_EN=1 on the first cycle after release.
- RAW hazard:
  - Issue R-type rd=5, then R-type src1=5 -> DE_BUBBLE=1 and PC_EN=0 until the cycle after WB_VALID with WB_RD=5.
  - STALL_COUNT equals the stall length.
- x0 and I-type:
  - Issue writer rd=0 -> BUSY_MAP stays 0.
  - I-type src2=busy reg and src1 free -> no stall.
- Branch:
  - BRANCH_TAKEN=1 while decode is hazarded -> FD_FLUSH=1, DE_BUBBLE=1, PC_EN=1, STALL=0.
  - The squashed writer does not set BUSY_MAP.
- Memory freeze:
  - MEM_REQ=1, MEM_READY=0 for 4 cycles, then 1 -> PIPE_EN=0 for 4 cycles, state returns to RUN.
  - BRANCH_TAKEN during the freeze has no effect.
- Timeout: MEM_TIMEOUT=8, hold MEM_READY=0 for 10 cycles -> MEM_ERR=1 from the 9th edge, stays 1 after MEM_READY, and clears only on RESET_N=0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush sequencer with register scoreboard
// Freezes on data-memory waits, squashes on taken branches, stalls decode on RAW hazards.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             de_valid,
  input  logic [2:0]       de_type,
  input  logic [4:0]       de_src1,
  input  logic [4:0]       de_src2,
  input  logic [4:0]       de_rd,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             de_bubble,
  output logic             pipe_en,
  output logic             stall_processor,
  output logic [31:0]      busy_map,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_err
);

  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;

  localparam int                WAIT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_MAX  = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       busy_next;
  logic              uses1;
  logic              uses2;
  logic              writer;
  logic              hazard;
  logic              freeze;
  logic              issue;

  always_comb begin
    uses1  = 1'b0;
    uses2  = 1'b0;
    writer = 1'b0;
    case (de_type)
      TYPE_R:         begin uses1 = 1'b1; uses2 = 1'b1; writer = 1'b1; end
      TYPE_I:         begin uses1 = 1'b1; writer = 1'b1; end
      TYPE_S, TYPE_B: begin uses1 = 1'b1; uses2 = 1'b1; end
      TYPE_U, TYPE_J: writer = 1'b1;
      default:        ;
    endcase
  end

  // Registered map only: a same-cycle writeback does not release the stall.
  assign hazard = de_valid &
                  ((uses1 & (de_src1 != 5'd0) & busy_map[de_src1]) |
                   (uses2 & (de_src2 != 5'd0) & busy_map[de_src2]));

  always_comb begin
    state_next      = state;
    freeze          = 1'b0;
    pc_en           = 1'b0;
    fd_en           = 1'b0;
    fd_flush        = 1'b1;
    de_bubble       = 1'b1;
    pipe_en         = 1'b0;
    stall_processor = 1'b0;
    if (reset_n) begin
      if (state == MEM_WAIT) freeze = ~mem_ready;
      else                   freeze = mem_req & ~mem_ready;
      state_next = freeze ? MEM_WAIT : RUN;
      if (freeze) begin
        fd_flush        = 1'b0;
        de_bubble       = 1'b0;
        stall_processor = 1'b1;
      end else if (branch_taken) begin
        pc_en   = 1'b1;
        fd_en   = 1'b1;
        pipe_en = 1'b1;
      end else if (hazard) begin
        fd_flush        = 1'b0;
        pipe_en         = 1'b1;
        stall_processor = 1'b1;
      end else begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        fd_flush  = 1'b0;
        de_bubble = 1'b0;
        pipe_en   = 1'b1;
      end
    end
  end

  assign issue = de_valid & writer & (de_rd != 5'd0) & pipe_en & ~de_bubble;

  always_comb begin
    busy_next = busy_map;
    if (wb_valid & pipe_en) busy_next[wb_rd] = 1'b0;
    if (issue)              busy_next[de_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      busy_map    <= '0;
      stall_count <= '0;
      mem_err     <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state    <= state_next;
      busy_map <= busy_next;
      if (stall_processor && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      // Held at zero in RUN so it starts clean on every MEM_WAIT entry.
      if (state == RUN)
        wait_cnt <= '0;
      else if (wait_cnt != TIMEOUT_MAX)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if ((state == MEM_WAIT) && (wait_cnt == TIMEOUT_LAST))
        mem_err <= 1'b1;
    end
  end

endmodule
